// File: rtl/usr_link_pkg.sv
// Shared types and constants for the shift-register serial link controller.
package usr_link_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SHIFT   = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic SEL_LOAD  = 1'b1;
  localparam logic SEL_SHIFT = 1'b0;

  localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/usr_link_if.sv
// Host handshake plus transmitter/receiver link signals of the serial link controller.
interface usr_link_if #(parameter int DATA_W = usr_link_pkg::DATA_W_DEF);
  logic [DATA_W-1:0] tx_data;
  logic [DATA_W-1:0] tx_hold;
  logic [DATA_W-1:0] rx_data;
  logic [DATA_W-1:0] rx_byte;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_select;
  logic              rx_select;
  logic              tx_shift_en;
  logic              serial_line;
  logic              rx_valid;
  logic              rx_ack;

  // slave: the controller; master: host plus transmitter/receiver pair
  modport slave (
    input  tx_data, tx_valid, rx_data, serial_line, rx_ack,
    output tx_ready, tx_hold, tx_select, rx_select, tx_shift_en, rx_byte, rx_valid
  );

  modport master (
    output tx_data, tx_valid, rx_data, serial_line, rx_ack,
    input  tx_ready, tx_hold, tx_select, rx_select, tx_shift_en, rx_byte, rx_valid
  );
endinterface

// File: rtl/usr_link_bit_counter.sv
// Up-counter with synchronous clear that stops at its terminal value.
module usr_link_bit_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] terminal,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !tc) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == terminal);

endmodule

// File: rtl/usr_link_controller.sv
// Load/shift/capture sequencer for the serial link; USR_LINK_PARITY_EN adds an
// appended even-parity bit and a parity check on the received frame.
//
// state   | meaning
// IDLE    | ready for a host byte
// LOAD    | transmitter parallel load from the hold register
// SHIFT   | transmitter shifts out, receiver shifts in
// CAPTURE | receiver word copied to rx_byte
// DONE    | rx_byte presented until rx_ack
module usr_link_controller
  import usr_link_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  localparam int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic    CLK,
  input  logic    RST,
  usr_link_if.slave lnk,
  output logic    busy,
  output logic    parity_err
);

`ifdef USR_LINK_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(DATA_W - 1 + PAR_BITS);

  state_t            state, state_nx;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] rx_byte_q;
  logic              cnt_clr, cnt_en, cnt_tc;
  logic              tx_ready_c, tx_select_c, rx_select_c, tx_shift_en_c, rx_valid_c;

  usr_link_bit_counter #(.CNT_W(CNT_W)) u_bit_cnt (
    .clk      (CLK),
    .rst      (RST),
    .clear    (cnt_clr),
    .enable   (cnt_en),
    .terminal (SHIFT_LAST),
    .tc       (cnt_tc)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    tx_ready_c    = 1'b0;
    tx_select_c   = SEL_SHIFT;
    rx_select_c   = 1'b0;
    tx_shift_en_c = 1'b0;
    rx_valid_c    = 1'b0;
    cnt_clr       = 1'b0;
    cnt_en        = 1'b0;
    case (state)
      IDLE: begin
        tx_ready_c = 1'b1;
        if (lnk.tx_valid) state_nx = LOAD;
      end
      LOAD: begin
        tx_select_c = SEL_LOAD;
        cnt_clr     = 1'b1;
        state_nx    = SHIFT;
      end
      SHIFT: begin
        tx_shift_en_c = 1'b1;
        rx_select_c   = 1'b1;
        cnt_en        = 1'b1;
        if (cnt_tc) state_nx = CAPTURE;
      end
      CAPTURE: begin
        state_nx = DONE;
      end
      DONE: begin
        rx_valid_c = 1'b1;
        if (lnk.rx_ack) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold      <= '0;
      rx_byte_q <= '0;
    end else begin
      if (state == IDLE && lnk.tx_valid) hold <= lnk.tx_data;
      if (state == CAPTURE) rx_byte_q <= lnk.rx_data;
    end
  end

`ifdef USR_LINK_PARITY_EN
  // Data bits plus the appended even-parity bit XOR to zero on a clean frame.
  logic par_acc;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      par_acc    <= 1'b0;
      parity_err <= 1'b0;
    end else if (state == LOAD) begin
      par_acc    <= 1'b0;
      parity_err <= 1'b0;
    end else if (state == SHIFT) begin
      par_acc <= par_acc ^ lnk.serial_line;
    end else if (state == CAPTURE) begin
      parity_err <= par_acc;
    end
  end
`else
  logic unused_serial;
  assign unused_serial = lnk.serial_line;
  assign parity_err    = 1'b0;
`endif

  assign lnk.tx_ready    = tx_ready_c;
  assign lnk.tx_select   = tx_select_c;
  assign lnk.rx_select   = rx_select_c;
  assign lnk.tx_shift_en = tx_shift_en_c;
  assign lnk.rx_valid    = rx_valid_c;
  assign lnk.tx_hold     = hold;
  assign lnk.rx_byte     = rx_byte_q;
  assign busy            = (state != IDLE);

endmodule

// File: tb/tb_usr_link_controller.sv
// Directed bench for usr_link_controller with a behavioural transmitter/receiver pair.
module tb_usr_link_controller;

  localparam int DATA_W = 8;
`ifdef USR_LINK_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FW  = DATA_W + PAR;
  localparam int LAT = DATA_W + 3 + PAR;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic busy;
  logic parity_err;

  usr_link_if #(.DATA_W(DATA_W)) lnk();

  usr_link_controller #(.DATA_W(DATA_W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .lnk        (lnk.slave),
    .busy       (busy),
    .parity_err (parity_err)
  );

  always #5 CLK = ~CLK;

  // transmitter (MSB first, optional appended parity) and receiver models
  logic [FW-1:0] tx_sr = '0;
  logic [FW-1:0] rx_sr = '0;
  int            shift_idx = 0;
  logic          flip_en = 1'b0;

  function automatic logic [FW-1:0] load_word(input logic [DATA_W-1:0] w);
`ifdef USR_LINK_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction

  always @(posedge CLK) begin
    if (lnk.tx_select) tx_sr <= load_word(lnk.tx_hold);
    else if (lnk.tx_shift_en) tx_sr <= tx_sr << 1;
    if (lnk.rx_select) rx_sr <= {rx_sr[FW-2:0], lnk.serial_line};
    if (lnk.tx_select) shift_idx <= 0;
    else if (lnk.rx_select) shift_idx <= shift_idx + 1;
  end

  assign lnk.serial_line = tx_sr[FW-1] ^ (flip_en && shift_idx == 3);
  assign lnk.rx_data     = rx_sr[FW-1 -: DATA_W];

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!lnk.rx_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_valid_seen"}, 32'(lnk.rx_valid), 32'd1);
  endtask

  task automatic ack();
    lnk.rx_ack = 1'b1;
    tick();
    lnk.rx_ack = 1'b0;
  endtask

  // one frame from IDLE; tx_data switches to alt right after the accept edge
  task automatic run_frame(input string tag, input logic [7:0] d, input logic [7:0] alt,
                           input logic [7:0] exp_byte, input logic exp_perr);
    int n;
    int sel_cnt;
    n = 0;
    sel_cnt = 0;
    lnk.tx_data  = d;
    lnk.tx_valid = 1'b1;
    do begin
      tick();
      n++;
      if (n == 1) begin
        lnk.tx_valid = 1'b0;
        lnk.tx_data  = alt;
      end
      if (lnk.tx_select) sel_cnt++;
    end while (!lnk.rx_valid && n < 40);
    check({tag, "_latency"}, 32'(n), 32'(LAT));
    check({tag, "_byte"}, 32'(lnk.rx_byte), 32'(exp_byte));
    check({tag, "_loads"}, 32'(sel_cnt), 32'd1);
    check({tag, "_parity"}, 32'(parity_err), 32'(exp_perr));
    ack();
    check({tag, "_valid_drop"}, 32'(lnk.rx_valid), 32'd0);
  endtask

  initial begin
    int bad;
    int k;
    int m;
    int t_v[3];
    logic [7:0] b_v[3];
    logic [7:0] vec[3];

    lnk.tx_data  = '0;
    lnk.tx_valid = 1'b0;
    lnk.rx_ack   = 1'b0;

    #1 RST = 1'b1;
    #11;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_select", 32'(lnk.tx_select), 32'd0);
    check("rst_rx_select", 32'(lnk.rx_select), 32'd0);
    check("rst_rx_valid", 32'(lnk.rx_valid), 32'd0);
    check("rst_rx_byte", 32'(lnk.rx_byte), 32'd0);
    check("rst_parity", 32'(parity_err), 32'd0);
    check("rst_tx_ready", 32'(lnk.tx_ready), 32'd1);
    #1 RST = 1'b0;
    tick();

    // single frame with cycle-exact select timing
    lnk.tx_data  = 8'hA5;
    lnk.tx_valid = 1'b1;
    check("s_ready_c0", 32'(lnk.tx_ready), 32'd1);
    tick();
    lnk.tx_valid = 1'b0;
    check("s_tx_select_c1", 32'(lnk.tx_select), 32'd1);
    check("s_rx_select_c1", 32'(lnk.rx_select), 32'd0);
    check("s_busy_c1", 32'(busy), 32'd1);
    bad = 0;
    for (int c = 2; c <= LAT - 2; c++) begin
      tick();
      if (lnk.rx_select !== 1'b1 || lnk.tx_select !== 1'b0 || lnk.tx_shift_en !== 1'b1) bad++;
    end
    check("s_shift_window", 32'(bad), 32'd0);
    tick();
    check("s_capture_rx_select", 32'(lnk.rx_select), 32'd0);
    check("s_capture_valid", 32'(lnk.rx_valid), 32'd0);
    tick();
    check("s_valid_at_lat", 32'(lnk.rx_valid), 32'd1);
    check("s_byte", 32'(lnk.rx_byte), 32'hA5);
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (lnk.rx_valid !== 1'b1 || lnk.rx_byte !== 8'hA5) bad++;
    end
    check("s_valid_hold", 32'(bad), 32'd0);
    ack();
    check("s_valid_drop", 32'(lnk.rx_valid), 32'd0);
    check("s_ready_back", 32'(lnk.tx_ready), 32'd1);
    check("s_parity", 32'(parity_err), 32'd0);

    // handshake stall: DONE ignores a waiting host byte
    lnk.tx_data  = 8'h96;
    lnk.tx_valid = 1'b1;
    tick();
    lnk.tx_valid = 1'b0;
    wait_valid("stall_first");
    lnk.tx_data  = 8'h3C;
    lnk.tx_valid = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (lnk.tx_ready !== 1'b0 || lnk.rx_byte !== 8'h96 || lnk.rx_valid !== 1'b1) bad++;
    end
    check("stall_hold", 32'(bad), 32'd0);
    ack();
    check("stall_idle_ready", 32'(lnk.tx_ready), 32'd1);
    check("stall_idle_busy", 32'(busy), 32'd0);
    tick();
    lnk.tx_valid = 1'b0;
    check("stall_accept_load", 32'(lnk.tx_select), 32'd1);
    wait_valid("stall_second");
    check("stall_second_byte", 32'(lnk.rx_byte), 32'h3C);
    ack();

    // back-to-back with rx_ack tied high
    vec[0] = 8'h00;
    vec[1] = 8'hFF;
    vec[2] = 8'h81;
    lnk.rx_ack   = 1'b1;
    lnk.tx_data  = vec[0];
    lnk.tx_valid = 1'b1;
    k = 1;
    m = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      tick();
      if (lnk.rx_valid && m < 3) begin
        t_v[m] = cyc;
        b_v[m] = lnk.rx_byte;
        m++;
      end
      if (lnk.tx_ready) begin
        if (k < 3) begin
          lnk.tx_data = vec[k];
          k++;
        end else begin
          lnk.tx_valid = 1'b0;
        end
      end
    end
    lnk.rx_ack   = 1'b0;
    lnk.tx_valid = 1'b0;
    check("b2b_count", 32'(m), 32'd3);
    if (m == 3) begin
      check("b2b_byte0", 32'(b_v[0]), 32'h00);
      check("b2b_byte1", 32'(b_v[1]), 32'hFF);
      check("b2b_byte2", 32'(b_v[2]), 32'h81);
      check("b2b_first", 32'(t_v[0]), 32'(LAT));
      check("b2b_gap01", 32'(t_v[1] - t_v[0]), 32'(LAT + 1));
      check("b2b_gap12", 32'(t_v[2] - t_v[1]), 32'(LAT + 1));
    end

    // asynchronous reset in the fifth SHIFT cycle
    lnk.tx_data  = 8'hC3;
    lnk.tx_valid = 1'b1;
    tick();
    lnk.tx_valid = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    check("rst_mid_in_shift", 32'(lnk.rx_select), 32'd1);
    #3 RST = 1'b1;
    #1;
    check("rst_mid_tx_select", 32'(lnk.tx_select), 32'd0);
    check("rst_mid_rx_select", 32'(lnk.rx_select), 32'd0);
    check("rst_mid_shift_en", 32'(lnk.tx_shift_en), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_ready", 32'(lnk.tx_ready), 32'd1);
    check("rst_mid_rx_byte", 32'(lnk.rx_byte), 32'd0);
    #2 RST = 1'b0;
    bad = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (lnk.rx_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("rst_mid_no_valid", 32'(bad), 32'd0);
    run_frame("after_rst", 8'h5A, 8'h5A, 8'h5A, 1'b0);

    // tx_data change after accept must not reach the link
    run_frame("hold", 8'h11, 8'hEE, 8'h11, 1'b0);

`ifdef USR_LINK_PARITY_EN
    run_frame("par_ok", 8'h07, 8'h07, 8'h07, 1'b0);
    flip_en = 1'b1;
    run_frame("par_bad", 8'h07, 8'h07, 8'h17, 1'b1);
    flip_en = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/usr_link_controller.md
Name: usr_link_controller

Overview:
- Sequencing controller for the shift-register serial link: transmitter shift register (parallel load / serial shift) feeding the receiver shift register.
- Accepts a parallel byte on a valid/ready handshake and drives the transmitter and receiver select lines for one load and DATA_W shifts.
- Captures the receiver's parallel word and presents it on a valid/ack handshake.
- Sits between the host logic and the transmitter/receiver pair. It is the only driver of both select lines.

Parameters:
- DATA_W, 8, bits per frame. Legal range 2..32.
- CNT_W, $clog2(DATA_W+1), bit-counter width. Derived; do not override.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- tx_data  input  DATA_W  byte to send. Sampled on the accept cycle.
- tx_valid  input  1  host has a byte.
- tx_ready  output  1  controller can accept. Equals (state==IDLE), combinational from state only.
- tx_select  output  1  to transmitter: 1 = parallel load, 0 = shift/hold.
- rx_select  output  1  to receiver: 1 = shift in, 0 = hold.
- tx_shift_en  output  1  to transmitter: 1 = shift this cycle.
- rx_data  input  DATA_W  receiver parallel output.
- serial_line  input  1  serial line between transmitter and receiver. Monitored only.
- rx_byte  output  DATA_W  captured word.
- rx_valid  output  1  rx_byte is valid.
- rx_ack  input  1  host consumed rx_byte.
- busy  output  1  high in any state other than IDLE.
- parity_err  output  1  parity mismatch on the last frame. Tied 0 when the optional feature is off.

Behaviour:
- Reset (async, RST=1): state=IDLE, bit_cnt=0, hold register=0, rx_byte=0. All select and valid outputs are 0, parity_err=0. Reset mid-frame discards the frame; no partial rx_valid is produced.
- IDLE: tx_ready=1. When tx_valid & tx_ready, latch tx_data into the hold register and go to LOAD.
- LOAD (1 cycle):
  - tx_select=1, tx_shift_en=0, rx_select=0.
  - Clear bit_cnt; go to SHIFT.
- SHIFT (DATA_W cycles):
  - tx_select=0, tx_shift_en=1, rx_select=1; bit_cnt increments every cycle.
  - When bit_cnt==DATA_W-1, go to CAPTURE.
- CAPTURE (1 cycle):
  - All selects 0.
  - rx_byte <= rx_data.
  - Go to DONE.
- DONE:
  - rx_valid=1; rx_byte is held stable.
  - When rx_ack=1, go to IDLE; rx_valid falls on the next edge.
  - rx_ack outside DONE is ignored.
- Latency: accept edge at cycle 0; LOAD in cycle 1; SHIFT in cycles 2..DATA_W+1; CAPTURE in cycle DATA_W+2; rx_valid first high in cycle DATA_W+3 (11 for DATA_W=8).
- Back-to-back: tx_valid held high during DONE is not accepted. After the rx_ack edge, tx_ready rises and the next accept happens in the following cycle, giving a minimum 1-cycle IDLE gap.
- tx_data changes after accept have no effect, because the hold register is used.
- Counter never wraps. bit_cnt saturates at the value reached in SHIFT and is cleared in LOAD.
- Illegal state encoding recovers to IDLE on the next edge.

Optional Feature:
- Macro: USR_LINK_PARITY_EN.
- Defined:
  - SHIFT lasts DATA_W+1 cycles. The extra cycle carries even parity of the hold register, which the transmitter path appends.
  - The controller XOR-accumulates serial_line over all DATA_W+1 shift cycles.
  - In CAPTURE, parity_err <= accumulator (nonzero = error). parity_err is held until the next LOAD.
  - Latency becomes DATA_W+4.
- Not defined: SHIFT lasts DATA_W cycles, parity_err is constant 0, and the accumulator logic is absent.

Decomposition:
- Package usr_link_pkg:
  - state typedef: IDLE, LOAD, SHIFT, CAPTURE, DONE.
  - Select encoding constants: SEL_LOAD=1, SEL_SHIFT=0.
  - DATA_W default constant.
- One sub-module, usr_link_bit_counter: clear, enable, terminal-count compare, CNT_W wide, async reset.

Test Plan:
- Single frame: RST pulse, then tx_data=8'hA5 with tx_valid for 1 cycle, rx_data model returns 8'hA5.
  - Expected: tx_select high exactly in cycle 1; rx_select high in cycles 2..9.
  - Expected: rx_valid rises in cycle 11 with rx_byte=8'hA5 and holds until rx_ack.
- Handshake stall: keep rx_ack=0 for 20 cycles while tx_valid=1 with tx_data=8'h3C.
  - Expected: tx_ready=0 and rx_byte unchanged throughout.
  - After rx_ack, the second frame is accepted one cycle after IDLE is re-entered.
- Back-to-back: frames 8'h00, 8'hFF, 8'h81 with rx_ack tied high.
  - Expected: three rx_valid pulses with matching rx_byte, spaced 12 cycles apart.
- Reset mid-frame: assert RST asynchronously in SHIFT cycle 5.
  - Expected: all outputs 0 immediately and state IDLE.
  - Expected: no rx_valid; the next frame 8'h5A completes normally.
- Input hold: change tx_data from 8'h11 to 8'hEE the cycle after accept.
  - Expected: the hold register transmits 8'h11; tx_select is never reasserted mid-frame.
- Parity (USR_LINK_PARITY_EN): send 8'h07 with a correct parity bit, then flip one serial_line bit.
  - Expected: first frame parity_err=0 with rx_valid in cycle 12; second frame parity_err=1.
